// File: rtl/shifter_pipe_if.sv
// shifter_pipe_if: operand/result bus with valid/ready handshakes for shifter_pipe
interface shifter_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [SHAMT_WIDTH-1:0] B;
  logic [1:0] Shiftop;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] Result;
  modport master (
    output in_valid, A, B, Shiftop, out_ready,
    input  in_ready, out_valid, Result
  );
  modport slave (
    input  in_valid, A, B, Shiftop, out_ready,
    output in_ready, out_valid, Result
  );
endinterface

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready flow control
module shifter_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  shifter_pipe_if.slave bus
);
  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] ROR = 2'b01;
  localparam logic [1:0] SRA = 2'b11;
  logic [STAGES-1:0] v_q, v_d, s_q, s_d;
  logic [DATA_WIDTH-1:0] d_q [STAGES];
  logic [DATA_WIDTH-1:0] d_d [STAGES];
  logic [SHAMT_WIDTH-1:0] b_q [STAGES];
  logic [SHAMT_WIDTH-1:0] b_d [STAGES];
  logic [1:0] op_q [STAGES];
  logic [1:0] op_d [STAGES];
  logic adv;
  logic unused_tail;
  // one shift level by 2^k; right shifts take their fill from the mode (zero, carried sign, or wrapped bits)
  function automatic logic [DATA_WIDTH-1:0] level(input logic [DATA_WIDTH-1:0] x, input int k,
                                                  input logic [1:0] op, input logic s);
    int n;
    logic [DATA_WIDTH-1:0] fill;
    n = 1 << k;
    fill = op == ROR ? x << (DATA_WIDTH - n) : op == SRA ? {DATA_WIDTH{s}} << (DATA_WIDTH - n) : '0;
    return op == SLL ? x << n : (x >> n) | fill;
  endfunction
  assign adv = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = rst && adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.Result = d_q[STAGES-1];
  assign unused_tail = ^{s_q[STAGES-1], b_q[STAGES-1], op_q[STAGES-1]};
  // stage inputs from the predecessor register, then the shift levels assigned to each stage
  always_comb begin
    v_d[0] = bus.in_valid;
    s_d[0] = bus.A[DATA_WIDTH-1];
    d_d[0] = bus.A;
    b_d[0] = bus.B;
    op_d[0] = bus.Shiftop;
    for (int i = 1; i < STAGES; i++) begin
      v_d[i] = v_q[i-1];
      s_d[i] = s_q[i-1];
      d_d[i] = d_q[i-1];
      b_d[i] = b_q[i-1];
      op_d[i] = op_q[i-1];
    end
    for (int i = 0; i < STAGES; i++)
      for (int k = 0; k < SHAMT_WIDTH; k++)
        if (k * STAGES / SHAMT_WIDTH == i && b_d[i][k]) d_d[i] = level(d_d[i], k, op_d[i], s_d[i]);
  end
  // whole pipe advances together; a held output stalls every stage, bubbles included
  always_ff @(posedge clk)
    if (!rst) begin
      v_q <= '0;
      s_q <= '0;
      d_q <= '{default: '0};
      b_q <= '{default: '0};
      op_q <= '{default: '0};
    end else if (adv) begin
      v_q <= v_d;
      s_q <= s_d;
      d_q <= d_d;
      b_q <= b_d;
      op_q <= op_d;
    end
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed and random scoreboard bench for shifter_pipe at three configurations
module tb_shifter_pipe;
  typedef struct {
    logic [31:0] v;
    int acc;
  } ent_t;
  logic clk = 0;
  logic rst = 0;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  bit lat_en = 1;
  logic [31:0] pend0 = 0;
  logic [31:0] pend1 = 0;
  ent_t q0[$], q1[$], q2[$];
  shifter_pipe_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) b0 ();
  shifter_pipe_if #(.DATA_WIDTH(8), .SHAMT_WIDTH(3)) b1 ();
  shifter_pipe_if #(.DATA_WIDTH(8), .SHAMT_WIDTH(3)) b2 ();
  shifter_pipe #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .STAGES(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  shifter_pipe #(.DATA_WIDTH(8), .SHAMT_WIDTH(3), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  shifter_pipe #(.DATA_WIDTH(8), .SHAMT_WIDTH(3), .STAGES(3)) u2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [7:0] ref8(input logic [7:0] a, input logic [2:0] b, input logic [1:0] op);
    logic [15:0] w;
    w = {a, a} >> b;
    return op == 2'b00 ? a << b : op == 2'b10 ? a >> b : op == 2'b11 ? 8'($signed(a) >>> b) : w[7:0];
  endfunction
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (b0.out_valid && b0.out_ready) begin
        if (q0.size() == 0) chk("d0 spurious out_valid", 32'(b0.out_valid), 0);
        else begin
          e = q0.pop_front();
          chk("d0 result", b0.Result, e.v);
          if (lat_en) chk("d0 latency", 32'(cyc - e.acc), 1);
        end
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) chk("d1 spurious out_valid", 32'(b1.out_valid), 0);
        else begin
          e = q1.pop_front();
          chk("d1 result", 32'(b1.Result), e.v);
          chk("d1 latency", 32'(cyc - e.acc), 0);
        end
      end
      if (b2.out_valid && b2.out_ready) begin
        if (q2.size() == 0) chk("d2 spurious out_valid", 32'(b2.out_valid), 0);
        else begin
          e = q2.pop_front();
          chk("d2 result", 32'(b2.Result), e.v);
          chk("d2 latency", 32'(cyc - e.acc), 2);
        end
      end
      if (b0.in_valid && b0.in_ready) q0.push_back('{pend0, cyc + 1});
      if (b1.in_valid && b1.in_ready) q1.push_back('{pend1, cyc + 1});
      if (b2.in_valid && b2.in_ready) q2.push_back('{pend1, cyc + 1});
    end
  end
  task automatic set0(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op, input logic [31:0] e);
    b0.A = a;
    b0.B = b;
    b0.Shiftop = op;
    pend0 = e;
    b0.in_valid = 1;
  endtask
  task automatic acc0();
    int n = 0;
    @(negedge clk);
    while (!b0.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n == 20) chk("d0 accept timeout", 32'(b0.in_ready), 1);
    @(posedge clk);
    #1;
  endtask
  task automatic send0(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op, input logic [31:0] e);
    set0(a, b, op, e);
    acc0();
  endtask
  task automatic idle(input int n);
    b0.in_valid = 0;
    b1.in_valid = 0;
    b2.in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [7:0] ra;
    logic [2:0] rb;
    logic [1:0] rop;
    b0.in_valid = 0; b0.out_ready = 1; b0.A = 0; b0.B = 0; b0.Shiftop = 0;
    b1.in_valid = 0; b1.out_ready = 1; b1.A = 0; b1.B = 0; b1.Shiftop = 0;
    b2.in_valid = 0; b2.out_ready = 1; b2.A = 0; b2.B = 0; b2.Shiftop = 0;
    repeat (2) begin
      @(negedge clk);
      chk("reset in_ready", 32'(b0.in_ready), 0);
      chk("reset out_valid", 32'(b0.out_valid), 0);
      chk("reset Result", b0.Result, 0);
    end
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("idle in_ready", 32'(b0.in_ready), 1);
    chk("idle out_valid", 32'(b0.out_valid), 0);
    chk("idle Result", b0.Result, 0);
    @(posedge clk);
    #1;
    send0(32'h8000_00F1, 4, 2'b00, 32'h0000_0F10);
    send0(32'h8000_00F1, 4, 2'b10, 32'h0800_000F);
    send0(32'h8000_00F1, 4, 2'b11, 32'hF800_000F);
    send0(32'h8000_00F1, 4, 2'b01, 32'h1800_000F);
    idle(4);
    send0(32'hFFFF_FFFF, 31, 2'b10, 32'h0000_0001);
    send0(32'hFFFF_FFFF, 31, 2'b11, 32'hFFFF_FFFF);
    send0(32'h0000_0001, 31, 2'b00, 32'h8000_0000);
    send0(32'h1234_5678, 0, 2'b01, 32'h1234_5678);
    idle(4);
    lat_en = 0;
    send0(32'hDEAD_BEEF, 1, 2'b10, 32'h6F56_DF77);
    send0(32'h0000_00FF, 8, 2'b00, 32'h0000_FF00);
    set0(32'hF000_0000, 4, 2'b11, 32'hFF00_0000);
    b0.out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall in_ready", 32'(b0.in_ready), 0);
      chk("stall out_valid", 32'(b0.out_valid), 1);
      chk("stall Result", b0.Result, 32'h6F56_DF77);
      @(posedge clk);
      #1;
    end
    b0.out_ready = 1;
    acc0();
    send0(32'h0000_0003, 1, 2'b01, 32'h8000_0001);
    send0(32'h1234_5678, 4, 2'b00, 32'h2345_6780);
    idle(6);
    chk("bp drained", 32'(q0.size()), 0);
    lat_en = 1;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 3'($urandom_range(0, 7));
      rop = 2'($urandom_range(0, 3));
      b1.A = ra; b1.B = rb; b1.Shiftop = rop;
      b2.A = ra; b2.B = rb; b2.Shiftop = rop;
      pend1 = {24'b0, ref8(ra, rb, rop)};
      b1.in_valid = $urandom_range(0, 3) != 0;
      b2.in_valid = b1.in_valid;
      @(negedge clk);
      chk("sweep in_ready", 32'({b1.in_ready, b2.in_ready}), 3);
      @(posedge clk);
      #1;
    end
    idle(6);
    send0(32'hAAAA_0000, 3, 2'b10, 32'h1555_4000);
    send0(32'h0000_0055, 2, 2'b00, 32'h0000_0154);
    rst = 0;
    b0.in_valid = 0;
    @(posedge clk);
    #1;
    rst = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post-reset out_valid", 32'(b0.out_valid), 0);
      @(posedge clk);
      #1;
    end
    send0(32'h0000_0010, 1, 2'b00, 32'h0000_0020);
    idle(4);
    chk("q0 empty", 32'(q0.size()), 0);
    chk("q1 empty", 32'(q1.size()), 0);
    chk("q2 empty", 32'(q2.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
